// File: rtl/bram_addr_gen_pkg.sv
// Shared definitions for the BRAM write-address generator and its read-side peer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package bram_addr_gen_pkg;

  // Capture FSM encodings; the read-side DMA block decodes the same values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the hold cycle counter.
  localparam int TIMER_W = 8;

  // Channel index width: at least one bit even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/bram_addr_gen_hold_timer.sv
// Hold timer: 8-bit cycle counter with synchronous load-to-zero and count enable.
// Latency: count updates one cycle after load/en; tc is a compare on the count register.
// Backpressure: none; the owner decides when to load or enable.
// Ports: clk, rst_n (async, active low), load (clear count, wins over en), en (increment),
//        term (terminal value), tc (count == term).
module hold_timer
  import bram_addr_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] term,
  output logic               tc
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/bram_addr_gen.sv
// BRAM write-address generator: one registered write strobe + byte address per accepted sample.
// Latency: we/addr/ch one cycle after acceptance; address advances HOLD_CYC+1 cycles after that.
// Backpressure: none upstream; samples offered while holding are dropped and flagged in overrun.
// Ports: clk, rst_n; hab (inhibit new acceptances), valid, mode (0 one-shot, 1 continuous),
//        clear (sync restart); we, addr, ch, bank, bank_done, busy, overrun, done.
module bram_addr_gen
  import bram_addr_gen_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              STRIDE     = 4,
  parameter int              HOLD_CYC   = 2,
  parameter int              DEPTH_LOG2 = 11,
  parameter int              N_CH       = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hab,
  input  logic                        valid,
  input  logic                        mode,
  input  logic                        clear,
  output logic                        we,
  output logic [ADDR_W-1:0]           addr,
  output logic [ch_width(N_CH)-1:0]   ch,
  output logic                        bank,
  output logic                        bank_done,
  output logic                        busy,
  output logic                        overrun,
  output logic                        done
);

  localparam int SW       = $clog2(STRIDE);
  localparam int BANK_BIT = DEPTH_LOG2 + SW;
  localparam int OFF_W    = BANK_BIT + 1;
  localparam int CH_W     = ch_width(N_CH);

  if (!is_pow2(STRIDE)) begin : g_bad_stride
    $error("bram_addr_gen: STRIDE must be a power of two");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("bram_addr_gen: N_CH must be at least 1");
  end
  if (ADDR_W <= BANK_BIT) begin : g_bad_addr_w
    $error("bram_addr_gen: ADDR_W must exceed the bank bit position");
  end
  if (HOLD_CYC < 0 || HOLD_CYC > 255) begin : g_bad_hold
    $error("bram_addr_gen: HOLD_CYC must be within 0..255");
  end

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   offset_q, offset_nxt;
  logic [DEPTH_LOG2:0] word_idx;
  logic               last_in_bank, last_word;
  logic               accept, advance, tc;

  assign word_idx     = offset_q[OFF_W-1:SW];
  assign last_in_bank = &word_idx[DEPTH_LOG2-1:0];
  assign last_word    = last_in_bank & word_idx[DEPTH_LOG2];
  // Natural wrap of the OFF_W-bit offset takes bank 1's last word back to 0.
  assign offset_nxt   = offset_q + OFF_W'(STRIDE);

  // clear outranks both acceptance and advance.
  assign accept  = (state_q == ST_IDLE) && valid && !hab && !clear;
  assign advance = (state_q == ST_HOLD) && tc && !clear;

  hold_timer u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (clear || accept || advance),
    .en    ((state_q == ST_HOLD) && !tc),
    .term  (TIMER_W'(HOLD_CYC)),
    .tc    (tc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; mode only matters at the advance past bank 1's last word.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_HOLD;
        ST_HOLD: if (tc) state_d = (last_word && !mode) ? ST_DONE : ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    busy = (state_q == ST_HOLD);
    done = (state_q == ST_DONE);
  end

  // Address, channel, strobe and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q  <= '0;
      addr      <= BASE_ADDR;
      ch        <= '0;
      we        <= 1'b0;
      bank_done <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      offset_q  <= '0;
      addr      <= BASE_ADDR;
      ch        <= '0;
      we        <= 1'b0;
      bank_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      we        <= accept;
      bank_done <= advance && last_in_bank;
      // DONE ignores samples silently; only a sample arriving mid-hold is an overrun.
      if ((state_q == ST_HOLD) && valid && !hab) begin
        overrun <= 1'b1;
      end
      if (advance) begin
        offset_q <= offset_nxt;
        addr     <= BASE_ADDR + ADDR_W'(offset_nxt);
        ch       <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
      end
    end
  end

  assign bank = offset_q[BANK_BIT];

endmodule

// File: tb/tb_bram_addr_gen.sv
module tb_bram_addr_gen;

  localparam int          HOLD       = 2;
  localparam int          N_WORDS    = 8;   // two banks of four words
  localparam int          BANK_WORDS = 4;
  localparam int          NCH        = 2;
  localparam logic [31:0] BASE       = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hab = 1'b0, valid = 1'b0, mode = 1'b0, clear = 1'b0;
  logic        we, bank, bank_done, busy, overrun, done;
  logic [31:0] addr;
  logic [0:0]  ch;

  bram_addr_gen #(
    .ADDR_W     (32),
    .BASE_ADDR  (32'h100),
    .STRIDE     (4),
    .HOLD_CYC   (HOLD),
    .DEPTH_LOG2 (2),
    .N_CH       (NCH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hab       (hab),
    .valid     (valid),
    .mode      (mode),
    .clear     (clear),
    .we        (we),
    .addr      (addr),
    .ch        (ch),
    .bank      (bank),
    .bank_done (bank_done),
    .busy      (busy),
    .overrun   (overrun),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Reference model: position in the 8-word buffer, channel, hold window, flags.
  int pos, chm, acc_edge;
  bit hold_act, done_m, ovr_m;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    int          c;
  } wexp_t;
  wexp_t we_q[$];
  int    bd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0; chm = 0; acc_edge = 0;
    hold_act = 0; done_m = 0; ovr_m = 0;
    we_q.delete();
    bd_q.delete();
  endtask

  // One clock edge of the specified behaviour, with the inputs that were applied to it.
  task automatic model_edge(input bit v, input bit h, input bit m, input bit c);
    wexp_t e;
    if (c) begin
      pos = 0; chm = 0; ovr_m = 0; done_m = 0; hold_act = 0;
      return;
    end
    if (hold_act) begin
      if (v && !h) ovr_m = 1;
      if (edge_n == acc_edge + HOLD + 1) begin
        if (pos % BANK_WORDS == BANK_WORDS - 1) bd_q.push_back(edge_n);
        if (pos == N_WORDS - 1 && !m) done_m = 1;
        pos = (pos + 1) % N_WORDS;
        chm = (chm + 1) % NCH;
        hold_act = 0;
      end
    end else if (!done_m && v && !h) begin
      hold_act = 1;
      acc_edge = edge_n;
      e.cyc = edge_n;
      e.a   = BASE + 32'(pos * 4);
      e.c   = chm;
      we_q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input bit h, input bit m, input bit c);
    valid = v; hab = h; mode = m; clear = c;
    @(posedge clk);
    #1;
    edge_n++;
    model_edge(v, h, m, c);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_we"},        32'(we),        0);
    chk({tag, "_addr"},      addr,           BASE);
    chk({tag, "_ch"},        32'(ch),        0);
    chk({tag, "_bank"},      32'(bank),      0);
    chk({tag, "_bank_done"}, 32'(bank_done), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_overrun"},   32'(overrun),   0);
    chk({tag, "_done"},      32'(done),      0);
  endtask

  // Assert reset between clock edges, check outputs respond immediately, then release.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    valid = 1'b0; hab = 1'b0; clear = 1'b0;
    #1;
    check_reset_state(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle against the model and drains the scoreboards.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("addr",    addr,           BASE + 32'(pos * 4));
      chk("ch",      32'(ch),        32'(chm));
      chk("bank",    32'(bank),      32'(pos / BANK_WORDS));
      chk("busy",    32'(busy),      32'(hold_act));
      chk("done",    32'(done),      32'(done_m));
      chk("overrun", 32'(overrun),   32'(ovr_m));
      if (we) begin
        if (we_q.size() == 0) begin
          chk("we_spurious", 32'(we), 0);
        end else begin
          wexp_t e;
          e = we_q.pop_front();
          chk("we_cycle", 32'(edge_n), 32'(e.cyc));
          chk("we_addr",  addr,        e.a);
          chk("we_ch",    32'(ch),     32'(e.c));
        end
      end else if (we_q.size() > 0 && we_q[0].cyc <= edge_n) begin
        chk("we_missing", 32'(we), 1);
        void'(we_q.pop_front());
      end
      if (bank_done) begin
        if (bd_q.size() == 0) begin
          chk("bank_done_spurious", 32'(bank_done), 0);
        end else begin
          chk("bank_done_cycle", 32'(edge_n), 32'(bd_q.pop_front()));
        end
      end else if (bd_q.size() > 0 && bd_q[0] <= edge_n) begin
        chk("bank_done_missing", 32'(bank_done), 1);
        void'(bd_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #2;
    async_reset("reset");

    // Single sample: strobe next cycle, address advances three cycles later.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);

    // Continuous valid: one write every four cycles, overrun latches.
    step(0, 0, 1, 1);
    repeat (20) step(1, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0);

    // Continuous ping-pong across both banks, back to the base address.
    step(0, 0, 1, 1);
    for (int i = 0; i < N_WORDS; i++) begin
      step(1, 0, 1, 0);
      repeat (HOLD + 1) step(0, 0, 1, 0);
    end
    step(0, 0, 1, 0);
    chk("pingpong_addr_wrap", addr, BASE);

    // One-shot: stops in DONE, ignores further samples, clear restarts.
    step(0, 0, 0, 1);
    for (int i = 0; i < N_WORDS; i++) begin
      step(1, 0, 0, 0);
      repeat (HOLD + 1) step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);
    chk("oneshot_done", 32'(done), 1);
    repeat (3) step(1, 0, 0, 0);
    chk("oneshot_no_overrun", 32'(overrun), 0);
    step(0, 0, 0, 1);
    chk("clear_done", 32'(done), 0);
    chk("clear_addr", addr, BASE);

    // Inhibit: no acceptance; raising hab mid-hold still lets the address advance.
    repeat (5) step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    repeat (HOLD + 1) step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    chk("hab_mid_hold_addr", addr, BASE + 32'd4);

    // Async reset in the middle of a hold, with overrun and address non-zero.
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    async_reset("midhold_reset");

    // clear and valid together: clear wins.
    step(1, 0, 1, 1);
    step(0, 0, 1, 0);
    chk("clear_vs_valid_busy", 32'(busy), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
    end
    repeat (HOLD + 2) step(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
